// File: rtl/upipe_pkg.sv
// Shared definitions for the microinstruction pipeline stage: microword field
// positions (as functions of address/control widths), reset microword and
// sequencer opcode constants.
package upipe_pkg;

  localparam logic [2:0] CSEL_PASS = 3'd7;

  // Am2910 instruction codes referenced by the stage
  localparam logic [3:0] JZ   = 4'd0;
  localparam logic [3:0] JMAP = 4'd2;
  localparam logic [3:0] CJP  = 4'd3;
  localparam logic [3:0] CONT = 4'd14;

  localparam int I_W    = 4;
  localparam int CSEL_W = 3;

  // Microword layout, LSB first: BR, I, CSEL, CPOL, IRLD, SLD, CTL
  function automatic int br_lsb(int aw);
    return aw - aw;
  endfunction

  function automatic int i_lsb(int aw);
    return aw;
  endfunction

  function automatic int csel_lsb(int aw);
    return aw + 4;
  endfunction

  function automatic int cpol_bit(int aw);
    return aw + 7;
  endfunction

  function automatic int irld_bit(int aw);
    return aw + 8;
  endfunction

  function automatic int sld_bit(int aw);
    return aw + 9;
  endfunction

  function automatic int ctl_lsb(int aw);
    return aw + 10;
  endfunction

  function automatic int uw_of(int aw, int ctlw);
    return aw + ctlw + 10;
  endfunction

  // Reset microword: JZ with unconditional pass, every other field zero.
  // Returned wide; callers truncate to their microword width.
  function automatic logic [63:0] reset_uword(int aw);
    return (64'(CSEL_PASS) << csel_lsb(aw)) | (64'(JZ) << i_lsb(aw));
  endfunction

endpackage

// File: rtl/upipe_cc_select.sv
// Status register plus condition multiplexer. Produces the active-low
// condition returned to the sequencer, purely from registered state.
module upipe_cc_select
  import upipe_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       sld,
  input  logic [7:0] flags,
  input  logic [2:0] csel,
  input  logic       cpol,
  output logic       cc_n
);

  logic [7:0] status_reg;
  logic       sel;

  // Capture datapath status only when the current microword asks for it
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      status_reg <= 8'h00;
    end else if (sld) begin
      status_reg <= flags;
    end
  end

  // Select one status bit (or forced pass), apply polarity, invert for CCn
  always_comb begin
    sel = 1'b1;
    if (csel != CSEL_PASS) begin
      sel = status_reg[csel];
    end
    cc_n = ~(sel ^ cpol);
  end

endmodule

// File: rtl/upipe_stage.sv
// Microinstruction pipeline stage: writable control store addressed by the
// sequencer's Y, pipeline register, opcode register and D-input steering.
module upipe_stage
  import upipe_pkg::*;
#(
  parameter int AW   = 12,
  parameter int CTLW = 8,
  parameter int OPW  = 8
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [AW-1:0]                 Y,
  input  logic                          PLn,
  input  logic                          MAPn,
  input  logic                          VECTn,
  input  logic [7:0]                    flags,
  input  logic [OPW-1:0]                ir_di,
  input  logic [AW-1:0]                 vect_in,
  input  logic                          prog_we,
  input  logic [AW-1:0]                 prog_addr,
  input  logic [uw_of(AW, CTLW)-1:0]    prog_data,
  output logic [3:0]                    I,
  output logic                          CCn,
  output logic [AW-1:0]                 D,
  output logic [CTLW-1:0]               ctl,
  output logic                          d_err
);

  localparam int UW       = uw_of(AW, CTLW);
  localparam int BR_LSB   = br_lsb(AW);
  localparam int I_LSB    = i_lsb(AW);
  localparam int CSEL_LSB = csel_lsb(AW);
  localparam int CPOL_BIT = cpol_bit(AW);
  localparam int IRLD_BIT = irld_bit(AW);
  localparam int SLD_BIT  = sld_bit(AW);
  localparam int CTL_LSB  = ctl_lsb(AW);
  localparam logic [UW-1:0] RESET_UWORD = UW'(reset_uword(AW));

  logic [UW-1:0]  cs_mem [2**AW];
  logic [UW-1:0]  pipe_reg;
  logic [OPW-1:0] opcode_reg;
  logic [AW-1:0]  br;

  // Control store write port; reset blocks writes but never clears contents
  always_ff @(posedge clk) begin
    if (prog_we && resetn) begin
      cs_mem[prog_addr] <= prog_data;
    end
  end

  // Pipeline register fetches the addressed word (old content on collision)
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pipe_reg <= RESET_UWORD;
    end else begin
      pipe_reg <= cs_mem[Y];
    end
  end

  // Macro-opcode latch, enabled by the IRLD bit of the current microword
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      opcode_reg <= '0;
    end else if (pipe_reg[IRLD_BIT]) begin
      opcode_reg <= ir_di;
    end
  end

  assign br  = pipe_reg[BR_LSB +: AW];
  assign I   = pipe_reg[I_LSB +: I_W];
  assign ctl = pipe_reg[CTL_LSB +: CTLW];

  upipe_cc_select u_cc_select (
    .clk    (clk),
    .resetn (resetn),
    .sld    (pipe_reg[SLD_BIT]),
    .flags  (flags),
    .csel   (pipe_reg[CSEL_LSB +: CSEL_W]),
    .cpol   (pipe_reg[CPOL_BIT]),
    .cc_n   (CCn)
  );

  // D source steering with PLn > MAPn > VECTn priority; flag conflicts
  always_comb begin
    D = br;
    if (!PLn) begin
      D = br;
    end else if (!MAPn) begin
      D = AW'(opcode_reg) << (AW - OPW);
    end else if (!VECTn) begin
      D = vect_in;
    end
    d_err = (!PLn && !MAPn) || (!PLn && !VECTn) || (!MAPn && !VECTn);
  end

endmodule

// File: tb/tb_upipe_stage.sv
// Directed bench for upipe_stage: a vector table for single-cycle behaviour
// plus hand-written sequences for write collision and mid-run reset.
module tb_upipe_stage;

  logic        clk;
  logic        resetn;
  logic [11:0] Y;
  logic        PLn, MAPn, VECTn;
  logic [7:0]  flags;
  logic [7:0]  ir_di;
  logic [11:0] vect_in;
  logic        prog_we;
  logic [11:0] prog_addr;
  logic [29:0] prog_data;
  logic [3:0]  I;
  logic        CCn;
  logic [11:0] D;
  logic [7:0]  ctl;
  logic        d_err;

  int tests_run = 0;
  int tests_failed = 0;

  upipe_stage #(.AW(12), .CTLW(8), .OPW(8)) dut (
    .clk(clk), .resetn(resetn), .Y(Y), .PLn(PLn), .MAPn(MAPn), .VECTn(VECTn),
    .flags(flags), .ir_di(ir_di), .vect_in(vect_in), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .I(I), .CCn(CCn), .D(D),
    .ctl(ctl), .d_err(d_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] y;
    logic        pln, mapn, vectn;
    logic [7:0]  flg;
    logic [7:0]  ir;
    logic [11:0] vect;
    logic [3:0]  ei;
    logic        eccn;
    logic [11:0] ed;
    logic [7:0]  ectl;
    logic        ederr;
  } vec_t;

  vec_t vt [13];

  function automatic logic [29:0] mkw(input logic [11:0] br, input logic [3:0] i,
                                      input logic [2:0] csel, input logic cpol,
                                      input logic irld, input logic sld,
                                      input logic [7:0] c);
    return {c, sld, irld, cpol, csel, i, br};
  endfunction

  function automatic vec_t mkv(input logic [11:0] y, input logic pln, input logic mapn,
                               input logic vectn, input logic [7:0] flg, input logic [7:0] ir,
                               input logic [11:0] vect, input logic [3:0] ei, input logic eccn,
                               input logic [11:0] ed, input logic [7:0] ectl, input logic ederr);
    vec_t v;
    v.y = y; v.pln = pln; v.mapn = mapn; v.vectn = vectn; v.flg = flg; v.ir = ir;
    v.vect = vect; v.ei = ei; v.eccn = eccn; v.ed = ed; v.ectl = ectl; v.ederr = ederr;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] ei, input logic eccn,
                           input logic [11:0] ed, input logic [7:0] ectl, input logic ederr);
    check({tag, ".I"}, 32'(I), 32'(ei));
    check({tag, ".CCn"}, 32'(CCn), 32'(eccn));
    check({tag, ".D"}, 32'(D), 32'(ed));
    check({tag, ".ctl"}, 32'(ctl), 32'(ectl));
    check({tag, ".d_err"}, 32'(d_err), 32'(ederr));
    $display("[TB] %s: I=%0h CCn=%0b D=%0h ctl=%0h d_err=%0b", tag, I, CCn, D, ctl, d_err);
  endtask

  task automatic prog(input logic [11:0] a, input logic [29:0] w);
    @(negedge clk);
    prog_we = 1'b1; prog_addr = a; prog_data = w; Y = 12'h000;
    @(posedge clk);
    #1;
    prog_we = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; Y = '0; PLn = 1'b0; MAPn = 1'b1; VECTn = 1'b1;
    flags = '0; ir_di = '0; vect_in = '0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;

    // y, PLn, MAPn, VECTn, flags, ir_di, vect_in -> I, CCn, D, ctl, d_err
    vt[0]  = mkv(12'd0, 0, 1, 1, 8'h00, 8'h00, 12'h000, 4'd14, 0, 12'h000, 8'hA5, 0);
    vt[1]  = mkv(12'd5, 0, 1, 1, 8'h00, 8'h00, 12'h000, 4'd3,  1, 12'h123, 8'h00, 0);
    vt[2]  = mkv(12'd1, 0, 1, 1, 8'h04, 8'h00, 12'h000, 4'd14, 0, 12'h000, 8'h00, 0);
    vt[3]  = mkv(12'd2, 0, 1, 1, 8'h04, 8'h00, 12'h000, 4'd14, 0, 12'h222, 8'h00, 0);
    vt[4]  = mkv(12'd3, 0, 1, 1, 8'h00, 8'h00, 12'h000, 4'd14, 1, 12'h333, 8'h00, 0);
    vt[5]  = mkv(12'd4, 0, 1, 1, 8'h00, 8'h00, 12'h000, 4'd14, 1, 12'h444, 8'h5A, 0);
    vt[6]  = mkv(12'd6, 0, 1, 1, 8'h00, 8'h77, 12'h000, 4'd2,  0, 12'h666, 8'h00, 0);
    vt[7]  = mkv(12'd0, 1, 0, 1, 8'h00, 8'h3C, 12'h000, 4'd14, 0, 12'h3C0, 8'hA5, 0);
    vt[8]  = mkv(12'd0, 1, 0, 1, 8'h00, 8'h11, 12'h000, 4'd14, 0, 12'h3C0, 8'hA5, 0);
    vt[9]  = mkv(12'd4, 1, 1, 0, 8'h00, 8'h00, 12'hF00, 4'd14, 1, 12'hF00, 8'h5A, 0);
    vt[10] = mkv(12'd5, 0, 1, 0, 8'h00, 8'h00, 12'hF00, 4'd3,  0, 12'h123, 8'h00, 1);
    vt[11] = mkv(12'd5, 1, 0, 0, 8'h00, 8'h00, 12'hF00, 4'd3,  0, 12'h3C0, 8'h00, 1);
    vt[12] = mkv(12'd2, 1, 1, 1, 8'h00, 8'h00, 12'hF00, 4'd14, 0, 12'h222, 8'h00, 0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 4'd0, 0, 12'h000, 8'h00, 0);
    @(negedge clk);
    resetn = 1'b1;

    // Control store image
    prog(12'd0, mkw(12'h000, 4'd14, 3'd7, 0, 0, 0, 8'hA5));
    prog(12'd1, mkw(12'h000, 4'd14, 3'd7, 0, 0, 1, 8'h00));
    prog(12'd2, mkw(12'h222, 4'd14, 3'd2, 0, 0, 0, 8'h00));
    prog(12'd3, mkw(12'h333, 4'd14, 3'd2, 1, 0, 0, 8'h00));
    prog(12'd4, mkw(12'h444, 4'd14, 3'd7, 1, 0, 0, 8'h5A));
    prog(12'd5, mkw(12'h123, 4'd3,  3'd2, 0, 0, 0, 8'h00));
    prog(12'd6, mkw(12'h666, 4'd2,  3'd7, 0, 1, 0, 8'h00));
    prog(12'd7, mkw(12'h777, 4'd14, 3'd7, 0, 0, 0, 8'h00));

    // Table-driven single-cycle vectors
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      Y = vt[k].y; PLn = vt[k].pln; MAPn = vt[k].mapn; VECTn = vt[k].vectn;
      flags = vt[k].flg; ir_di = vt[k].ir; vect_in = vt[k].vect;
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", k), vt[k].ei, vt[k].eccn, vt[k].ed, vt[k].ectl, vt[k].ederr);
    end

    // Write/read collision: old word captured, new word seen on re-access
    @(negedge clk);
    Y = 12'd7; PLn = 1'b0; MAPn = 1'b1; VECTn = 1'b1; flags = 8'h00;
    prog_we = 1'b1; prog_addr = 12'd7; prog_data = mkw(12'h7AA, 4'd0, 3'd7, 0, 0, 0, 8'h00);
    @(posedge clk);
    #1;
    check_all("collide_old", 4'd14, 0, 12'h777, 8'h00, 0);
    @(negedge clk);
    prog_we = 1'b0;
    @(posedge clk);
    #1;
    check_all("collide_new", 4'd0, 0, 12'h7AA, 8'h00, 0);

    // Mid-run reset between edges, with a write pending that must be dropped
    @(negedge clk);
    Y = 12'd4;
    @(posedge clk);
    #1;
    check_all("pre_reset", 4'd14, 1, 12'h444, 8'h5A, 0);
    #2;
    resetn = 1'b0;
    #1;
    check_all("async_reset", 4'd0, 0, 12'h000, 8'h00, 0);
    @(negedge clk);
    prog_we = 1'b1; prog_addr = 12'd0; prog_data = mkw(12'h055, 4'd1, 3'd7, 0, 0, 0, 8'hFF);
    @(posedge clk);
    #1;
    @(negedge clk);
    prog_we = 1'b0; resetn = 1'b1; Y = 12'd0;
    @(posedge clk);
    #1;
    check_all("post_reset_fetch", 4'd14, 0, 12'h000, 8'hA5, 0);
    @(negedge clk);
    Y = 12'd2; PLn = 1'b1; MAPn = 1'b0;
    @(posedge clk);
    #1;
    check_all("post_reset_regs", 4'd14, 1, 12'h000, 8'h00, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Absolute watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
